// File: rtl/mips_multicycle_core_if.sv
// Unified memory port of the multi-cycle core: registered request, req/ready handshake.
interface mips_multicycle_core_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB over one ALU and one memory port,
// with alignment/illegal-opcode trap and a per-instruction retire pulse.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          STRICT_ALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_core_if.master mem,
    output logic [31:0]            pc_out,
    output logic                   retire,
    output logic                   trap
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic              req_q, req_d, we_q, we_d, retire_q, retire_d, trap_q, trap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       gpr_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              fetch_go;
    logic [31:0]       fetch_pc;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, alu_b, alu_y, br_target;
    logic        legal;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign simm      = {{16{ir_q[15]}}, ir_q[15:0]};
    assign br_target = pc_q + {simm[29:0], 2'b00};

    function automatic logic misaligned(input logic [31:0] a);
        return STRICT_ALIGN && (a[1:0] != 2'b00);
    endfunction

    function automatic logic [ADDR_W-1:0] to_addr(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return w[ADDR_W-1:0];
    endfunction

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                                      legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
    end

    // Single ALU: branches compare by subtraction, loads/stores/addi add the sign-extended immediate.
    always_comb begin
        alu_b = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE) ? b_q : simm;
        alu_y = a_q + alu_b;
        if (op == OP_BEQ || op == OP_BNE) begin
            alu_y = a_q - alu_b;
        end else if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_y = a_q - alu_b;
                FN_AND:  alu_y = a_q & alu_b;
                FN_OR:   alu_y = a_q | alu_b;
                FN_SLT:  alu_y = {31'd0, $signed(a_q) < $signed(alu_b)};
                default: alu_y = a_q + alu_b;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        retire_d = 1'b0;
        trap_d   = trap_q;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        fetch_go = 1'b0;
        fetch_pc = pc_q;
        case (state_q)
            S_FETCH: begin
                if (req_q) begin
                    if (mem.mem_ready) begin
                        ir_d    = mem.mem_rdata;
                        pc_d    = pc_q + 32'd4;
                        req_d   = 1'b0;
                        state_d = S_DECODE;
                    end
                end else if (misaligned(pc_q)) begin
                    state_d = S_TRAP;
                end else begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = to_addr(pc_q);
                end
            end
            S_DECODE: begin
                a_d = gpr_q[rs];
                b_d = gpr_q[rt];
                if (!legal) begin
                    state_d = S_TRAP;
                end else if (op == OP_J || op == OP_JAL) begin
                    fetch_go = 1'b1;
                    fetch_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
                    if (op == OP_JAL) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                end else if (op == OP_RTYPE && funct == FN_JR) begin
                    fetch_go = 1'b1;
                    fetch_pc = gpr_q[rs];
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ || op == OP_BNE) begin
                    fetch_go = 1'b1;
                    if ((alu_y == 32'd0) ^ (op == OP_BNE)) fetch_pc = br_target;
                end else if (op == OP_LW || op == OP_SW) begin
                    if (misaligned(alu_y)) begin
                        state_d = S_TRAP;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = (op == OP_SW);
                        addr_d  = to_addr(alu_y);
                        wdata_d = b_q;
                        state_d = S_MEM;
                    end
                end else begin
                    alu_d   = alu_y;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        fetch_go = 1'b1;
                    end else begin
                        alu_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_wdata = alu_q;
                fetch_go = 1'b1;
            end
            S_TRAP:  ;
            default: state_d = S_TRAP;
        endcase
        // The final state pre-issues the next fetch so a zero-wait FETCH costs one cycle.
        if (fetch_go) begin
            state_d  = S_FETCH;
            pc_d     = fetch_pc;
            retire_d = 1'b1;
            if (misaligned(fetch_pc)) begin
                req_d = 1'b0;
            end else begin
                req_d  = 1'b1;
                we_d   = 1'b0;
                addr_d = to_addr(fetch_pc);
            end
        end
        if (state_d == S_TRAP) begin
            req_d  = 1'b0;
            we_d   = 1'b0;
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
            if (rf_we && rf_waddr != 5'd0) gpr_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc_out        = pc_q;
    assign retire        = retire_q;
    assign trap          = trap_q;
endmodule
